e203_dtcm_arbt: RTL and testbench



---
 rtl/e203_dtcm_arbt_pkg.sv | 14 +
 rtl/e203_dtcm_arbt_if.sv | 49 ++++
 rtl/e203_dtcm_arbt_rsp_buf.sv | 73 +++++++
 rtl/e203_dtcm_arbt.sv | 73 +++++++
 tb/tb_e203_dtcm_arbt.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/e203_dtcm_arbt_pkg.sv
// Shared widths, channel count and sequencer state encoding for the DTCM arbiter.
package e203_dtcm_arbt_pkg;

   localparam int E203_DTCM_RAM_AW    = 12;
   localparam int E203_DTCM_RAM_DW    = 32;
   localparam int E203_DTCM_RAM_MW    = E203_DTCM_RAM_DW / 8;
   localparam int E203_DTCM_ARBT_CH_N = 2;

   typedef enum logic {
      E203_DTCM_ARBT_IDLE = 1'b0,
      E203_DTCM_ARBT_RSP  = 1'b1
   } arbt_state_e;

endpackage

// File: rtl/e203_dtcm_arbt_if.sv
// Bundle of both command/response channels plus the DTCM RAM port.
// The slave modport is the arbiter's view; master is the requesters' and RAM's view.
interface e203_dtcm_arbt_if
   import e203_dtcm_arbt_pkg::*;
#(
   parameter int AW = E203_DTCM_RAM_AW,
   parameter int DW = E203_DTCM_RAM_DW,
   parameter int MW = E203_DTCM_RAM_MW
);

   logic          ch0_cmd_valid, ch0_cmd_ready, ch0_cmd_read;
   logic [AW-1:0] ch0_cmd_addr;
   logic [DW-1:0] ch0_cmd_wdata;
   logic [MW-1:0] ch0_cmd_wmask;
   logic          ch0_rsp_valid, ch0_rsp_ready;
   logic [DW-1:0] ch0_rsp_rdata;

   logic          ch1_cmd_valid, ch1_cmd_ready, ch1_cmd_read;
   logic [AW-1:0] ch1_cmd_addr;
   logic [DW-1:0] ch1_cmd_wdata;
   logic [MW-1:0] ch1_cmd_wmask;
   logic          ch1_rsp_valid, ch1_rsp_ready;
   logic [DW-1:0] ch1_rsp_rdata;

   logic          ram_cs, ram_we;
   logic [AW-1:0] ram_addr;
   logic [MW-1:0] ram_wem;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  ch0_cmd_valid, ch0_cmd_read, ch0_cmd_addr, ch0_cmd_wdata, ch0_cmd_wmask, ch0_rsp_ready,
      input  ch1_cmd_valid, ch1_cmd_read, ch1_cmd_addr, ch1_cmd_wdata, ch1_cmd_wmask, ch1_rsp_ready,
      input  ram_dout,
      output ch0_cmd_ready, ch0_rsp_valid, ch0_rsp_rdata,
      output ch1_cmd_ready, ch1_rsp_valid, ch1_rsp_rdata,
      output ram_cs, ram_we, ram_addr, ram_wem, ram_din
   );

   modport master (
      output ch0_cmd_valid, ch0_cmd_read, ch0_cmd_addr, ch0_cmd_wdata, ch0_cmd_wmask, ch0_rsp_ready,
      output ch1_cmd_valid, ch1_cmd_read, ch1_cmd_addr, ch1_cmd_wdata, ch1_cmd_wmask, ch1_rsp_ready,
      output ram_dout,
      input  ch0_cmd_ready, ch0_rsp_valid, ch0_rsp_rdata,
      input  ch1_cmd_ready, ch1_rsp_valid, ch1_rsp_rdata,
      input  ram_cs, ram_we, ram_addr, ram_wem, ram_din
   );

endinterface

// File: rtl/e203_dtcm_arbt_rsp_buf.sv
// Single-outstanding response sequencer: tracks owner, returns live RAM data in the
// first response cycle and a held copy while the owner back-pressures.
module e203_dtcm_arbt_rsp_buf
   import e203_dtcm_arbt_pkg::*;
#(
   parameter int DW = E203_DTCM_RAM_DW
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_fire_i,
   input  logic                           cmd_ch_i,
   input  logic                           cmd_read_i,
   input  logic [DW-1:0]                  ram_dout_i,
   input  logic [E203_DTCM_ARBT_CH_N-1:0] rsp_ready_i,
   output logic                           can_acc_o,
   output logic                           rsp_valid0_o,
   output logic                           rsp_valid1_o,
   output logic [DW-1:0]                  rsp_rdata0_o,
   output logic [DW-1:0]                  rsp_rdata1_o
);

   arbt_state_e   state_q, state_d;
   logic          owner_q, owner_d;
   logic          first_q, first_d;
   logic          rd_q, rd_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          rsp_fire;
   logic [DW-1:0] rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= E203_DTCM_ARBT_IDLE;
         owner_q <= 1'b0;
         first_q <= 1'b0;
         rd_q    <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         first_q <= first_d;
         rd_q    <= rd_d;
         hold_q  <= hold_d;
      end
   end

   assign rsp_fire  = (state_q == E203_DTCM_ARBT_RSP) & rsp_ready_i[owner_q];
   assign can_acc_o = (state_q == E203_DTCM_ARBT_IDLE) | rsp_fire;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      first_d = 1'b0;
      rd_d    = rd_q;
      // RAM output is only guaranteed in the cycle right after the access.
      hold_d  = first_q ? ram_dout_i : hold_q;
      if (cmd_fire_i) begin
         state_d = E203_DTCM_ARBT_RSP;
         owner_d = cmd_ch_i;
         first_d = 1'b1;
         rd_d    = cmd_read_i;
      end else if (rsp_fire) begin
         state_d = E203_DTCM_ARBT_IDLE;
      end
   end

   assign rdata        = ~rd_q ? '0 : (first_q ? ram_dout_i : hold_q);
   assign rsp_valid0_o = (state_q == E203_DTCM_ARBT_RSP) & ~owner_q;
   assign rsp_valid1_o = (state_q == E203_DTCM_ARBT_RSP) &  owner_q;
   assign rsp_rdata0_o = rsp_valid0_o ? rdata : '0;
   assign rsp_rdata1_o = rsp_valid1_o ? rdata : '0;

endmodule

// File: rtl/e203_dtcm_arbt.sv
// Two-channel DTCM arbiter and RAM mux. Define E203_DTCM_ARBT_RR_EN for round-robin
// arbitration; otherwise channel 0 has fixed priority.
module e203_dtcm_arbt
   import e203_dtcm_arbt_pkg::*;
#(
   parameter int AW = E203_DTCM_RAM_AW,
   parameter int DW = E203_DTCM_RAM_DW,
   parameter int MW = E203_DTCM_RAM_MW
)
(
   input  logic             clk,
   input  logic             rst,
   e203_dtcm_arbt_if.slave  bus
);

   logic          grant0, grant1;
   logic          can_acc;
   logic          fire0, fire1, cmd_fire;
   logic          sel_read;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_din;
   logic [MW-1:0] sel_mask;

`ifdef E203_DTCM_ARBT_RR_EN
   logic last_q, last_d;

   assign grant0 = bus.ch0_cmd_valid & (~bus.ch1_cmd_valid |  last_q);
   assign grant1 = bus.ch1_cmd_valid & (~bus.ch0_cmd_valid | ~last_q);
   assign last_d = cmd_fire ? fire1 : last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= 1'b0;
      else     last_q <= last_d;
   end
`else
   assign grant0 = bus.ch0_cmd_valid;
   assign grant1 = bus.ch1_cmd_valid & ~bus.ch0_cmd_valid;
`endif

   // Ready is masked during reset because the sequencer reads IDLE then.
   assign bus.ch0_cmd_ready = ~rst & can_acc & grant0;
   assign bus.ch1_cmd_ready = ~rst & can_acc & grant1;
   assign fire0    = bus.ch0_cmd_valid & bus.ch0_cmd_ready;
   assign fire1    = bus.ch1_cmd_valid & bus.ch1_cmd_ready;
   assign cmd_fire = fire0 | fire1;

   assign sel_read = grant1 ? bus.ch1_cmd_read  : bus.ch0_cmd_read;
   assign sel_addr = grant1 ? bus.ch1_cmd_addr  : bus.ch0_cmd_addr;
   assign sel_din  = grant1 ? bus.ch1_cmd_wdata : bus.ch0_cmd_wdata;
   assign sel_mask = grant1 ? bus.ch1_cmd_wmask : bus.ch0_cmd_wmask;

   assign bus.ram_cs   = cmd_fire;
   assign bus.ram_we   = cmd_fire & ~sel_read;
   assign bus.ram_addr = sel_addr;
   assign bus.ram_din  = sel_din;
   assign bus.ram_wem  = (cmd_fire & ~sel_read) ? sel_mask : '0;

   e203_dtcm_arbt_rsp_buf #(.DW(DW)) u_rsp_buf (
      .clk          (clk),
      .rst          (rst),
      .cmd_fire_i   (cmd_fire),
      .cmd_ch_i     (fire1),
      .cmd_read_i   (sel_read),
      .ram_dout_i   (bus.ram_dout),
      .rsp_ready_i  ({bus.ch1_rsp_ready, bus.ch0_rsp_ready}),
      .can_acc_o    (can_acc),
      .rsp_valid0_o (bus.ch0_rsp_valid),
      .rsp_valid1_o (bus.ch1_rsp_valid),
      .rsp_rdata0_o (bus.ch0_rsp_rdata),
      .rsp_rdata1_o (bus.ch1_rsp_rdata)
   );

endmodule

// File: tb/tb_e203_dtcm_arbt.sv
// Self-checking bench for e203_dtcm_arbt: directed table, hand sequences, and a
// randomized phase against a transaction-level model with a shadow memory.
`timescale 1ns/1ps
module tb_e203_dtcm_arbt;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int MW = 4;

`ifdef E203_DTCM_ARBT_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   e203_dtcm_arbt_if #(.AW(AW), .DW(DW), .MW(MW)) bus ();
   e203_dtcm_arbt #(.AW(AW), .DW(DW), .MW(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // RAM macro model; output scrambles whenever no read happened to expose stale use.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.ram_cs & bus.ram_we)
         for (int b = 0; b < MW; b++)
            if (bus.ram_wem[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
      if (bus.ram_cs & ~bus.ram_we) bus.ram_dout <= mem[bus.ram_addr];
      else                          bus.ram_dout <= $urandom;
   end

   logic [DW-1:0] shadow [0:(1<<AW)-1];

   typedef struct {
      logic        ch;
      logic        rd;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic shadow_wr(input logic [11:0] ad, input logic [31:0] wd, input logic [3:0] mk);
      for (int b = 0; b < 4; b++)
         if (mk[b]) shadow[ad][8*b +: 8] = wd[8*b +: 8];
   endtask

   task automatic set_cmd(input logic ch, input logic v, input logic r, input logic [11:0] ad,
                          input logic [31:0] wd, input logic [3:0] mk);
      if (!ch) begin
         bus.ch0_cmd_valid = v; bus.ch0_cmd_read = r; bus.ch0_cmd_addr = ad;
         bus.ch0_cmd_wdata = wd; bus.ch0_cmd_wmask = mk;
      end else begin
         bus.ch1_cmd_valid = v; bus.ch1_cmd_read = r; bus.ch1_cmd_addr = ad;
         bus.ch1_cmd_wdata = wd; bus.ch1_cmd_wmask = mk;
      end
   endtask

   task automatic idle_inputs();
      set_cmd(1'b0, 1'b0, 1'b1, 12'h0, 32'h0, 4'h0);
      set_cmd(1'b1, 1'b0, 1'b1, 12'h0, 32'h0, 4'h0);
      bus.ch0_rsp_ready = 1'b1;
      bus.ch1_rsp_ready = 1'b1;
   endtask

   function automatic logic get_ready(input logic ch);
      return ch ? bus.ch1_cmd_ready : bus.ch0_cmd_ready;
   endfunction
   function automatic logic get_rvalid(input logic ch);
      return ch ? bus.ch1_rsp_valid : bus.ch0_rsp_valid;
   endfunction
   function automatic logic [31:0] get_rdata(input logic ch);
      return ch ? bus.ch1_rsp_rdata : bus.ch0_rsp_rdata;
   endfunction

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One isolated transaction: accept, then response one cycle later.
   task automatic do_txn(input logic ch, input logic rd, input logic [11:0] ad,
                         input logic [31:0] wd, input logic [3:0] mk, input logic [31:0] exp);
      set_cmd(ch, 1'b1, rd, ad, wd, mk);
      @(negedge clk);
      chk("txn_ready", get_ready(ch), 1'b1);
      chk("txn_cs", bus.ram_cs, 1'b1);
      chk("txn_we", bus.ram_we, !rd);
      chk("txn_wem", bus.ram_wem, rd ? 4'h0 : mk);
      chk("txn_addr", bus.ram_addr, ad);
      if (!rd) shadow_wr(ad, wd, mk);
      @(posedge clk); #1;
      set_cmd(ch, 1'b0, 1'b1, 12'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("txn_rsp_valid", get_rvalid(ch), 1'b1);
      chk("txn_other_valid", get_rvalid(!ch), 1'b0);
      chk("txn_rdata", get_rdata(ch), exp);
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] sdata(input int i);
      return 32'h9E3779B9 * (i + 1);
   endfunction

   logic        pend, pown, mlast, win, acc, can;
   logic [31:0] pdata;
   logic        v [2];
   logic        rdq [2];
   logic        rr [2];
   logic [11:0] aq [2];
   logic [31:0] wq [2];
   logic [3:0]  mq [2];
   int          g0, g1;

   initial begin
      tbl[0] = '{1'b0, 1'b0, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 12'h010, 32'h0,        4'hF, 32'hDEADBEEF};
      tbl[2] = '{1'b1, 1'b0, 12'h020, 32'h11223344, 4'hF, 32'h0};
      tbl[3] = '{1'b0, 1'b0, 12'h020, 32'hAABBCCDD, 4'h5, 32'h0};
      tbl[4] = '{1'b1, 1'b1, 12'h020, 32'h0,        4'hF, 32'h11BB33DD};
      tbl[5] = '{1'b1, 1'b0, 12'h030, 32'hCAFEF00D, 4'hF, 32'h0};
      tbl[6] = '{1'b0, 1'b1, 12'h030, 32'h0,        4'hF, 32'hCAFEF00D};
      tbl[7] = '{1'b1, 1'b1, 12'h010, 32'h0,        4'hF, 32'hDEADBEEF};

      // Reset values with both channels requesting.
      idle_inputs();
      set_cmd(1'b0, 1'b1, 1'b0, 12'h010, 32'h1, 4'hF);
      set_cmd(1'b1, 1'b1, 1'b0, 12'h020, 32'h2, 4'hF);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ready0", bus.ch0_cmd_ready, 1'b0);
      chk("rst_ready1", bus.ch1_cmd_ready, 1'b0);
      chk("rst_cs", bus.ram_cs, 1'b0);
      chk("rst_we", bus.ram_we, 1'b0);
      chk("rst_wem", bus.ram_wem, 4'h0);
      chk("rst_rvalid0", bus.ch0_rsp_valid, 1'b0);
      chk("rst_rvalid1", bus.ch1_rsp_valid, 1'b0);
      chk("rst_rdata0", bus.ch0_rsp_rdata, 32'h0);
      chk("rst_rdata1", bus.ch1_rsp_rdata, 32'h0);
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++)
         do_txn(tbl[i].ch, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].exp);

      // Back-pressure on ch1 while ch0 waits.
      bus.ch1_rsp_ready = 1'b0;
      set_cmd(1'b1, 1'b1, 1'b1, 12'h030, 32'h0, 4'h0);
      @(negedge clk);
      chk("bp_ready1", bus.ch1_cmd_ready, 1'b1);
      @(posedge clk); #1;
      set_cmd(1'b1, 1'b0, 1'b1, 12'h0, 32'h0, 4'h0);
      set_cmd(1'b0, 1'b1, 1'b1, 12'h010, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rvalid1", bus.ch1_rsp_valid, 1'b1);
         chk("bp_rdata1", bus.ch1_rsp_rdata, 32'hCAFEF00D);
         chk("bp_ready0", bus.ch0_cmd_ready, 1'b0);
         chk("bp_cs", bus.ram_cs, 1'b0);
         @(posedge clk); #1;
      end
      bus.ch1_rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready0", bus.ch0_cmd_ready, 1'b1);
      chk("bp_release_rdata1", bus.ch1_rsp_rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("bp_after_rvalid0", bus.ch0_rsp_valid, 1'b1);
      chk("bp_after_rdata0", bus.ch0_rsp_rdata, 32'hDEADBEEF);
      chk("bp_after_rvalid1", bus.ch1_rsp_valid, 1'b0);
      @(posedge clk); #1;

      // Contention from a fresh reset.
      do_reset();
      g0 = 0; g1 = 0;
      set_cmd(1'b0, 1'b1, 1'b1, 12'h010, 32'h0, 4'h0);
      set_cmd(1'b1, 1'b1, 1'b1, 12'h030, 32'h0, 4'h0);
      for (int c = 0; c <= 8; c++) begin
         if (c == 8) idle_inputs();
         @(negedge clk);
         if (c < 8) begin
            win = RR ? ((c % 2) == 0) : 1'b0;
            chk("cont_ready0", bus.ch0_cmd_ready, !win);
            chk("cont_ready1", bus.ch1_cmd_ready, win);
            if (bus.ch0_cmd_ready) g0++;
            if (bus.ch1_cmd_ready) g1++;
         end
         if (c > 0) begin
            win = RR ? (((c - 1) % 2) == 0) : 1'b0;
            chk("cont_rvalid", get_rvalid(win), 1'b1);
            chk("cont_rdata", get_rdata(win), win ? 32'hCAFEF00D : 32'hDEADBEEF);
         end
         @(posedge clk); #1;
      end
      chk("cont_g0", g0, RR ? 4 : 8);
      chk("cont_g1", g1, RR ? 4 : 0);

      // Streaming: 16 back-to-back writes, then 16 back-to-back reads.
      for (int ph = 0; ph < 2; ph++) begin
         for (int c = 0; c <= 16; c++) begin
            if (c < 16) set_cmd(1'b0, 1'b1, ph == 1, 12'(c), sdata(c), 4'hF);
            else        idle_inputs();
            @(negedge clk);
            if (c < 16) chk("stream_ready", bus.ch0_cmd_ready, 1'b1);
            if (c > 0) begin
               chk("stream_rvalid", bus.ch0_rsp_valid, 1'b1);
               chk("stream_rdata", bus.ch0_rsp_rdata, (ph == 1) ? sdata(c - 1) : 32'h0);
            end
            if (c < 16 && ph == 0) shadow_wr(12'(c), sdata(c), 4'hF);
            @(posedge clk); #1;
         end
      end

      // Reset in the cycle after a read fire drops the response.
      set_cmd(1'b0, 1'b1, 1'b1, 12'h010, 32'h0, 4'h0);
      @(negedge clk);
      chk("rmid_ready", bus.ch0_cmd_ready, 1'b1);
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("rmid_rvalid_now", bus.ch0_rsp_valid, 1'b0);
      chk("rmid_rdata_now", bus.ch0_rsp_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rmid_rvalid_after", bus.ch0_rsp_valid, 1'b0);
      @(posedge clk); #1;
      do_txn(1'b0, 1'b1, 12'h010, 32'h0, 4'hF, 32'hDEADBEEF);

      // Randomized traffic over a small, pre-initialized address window.
      for (int i = 0; i < 8; i++)
         do_txn(i[0], 1'b0, 12'h100 + 12'(i), $urandom, 4'hF, 32'h0);
      do_reset();
      pend = 1'b0; pown = 1'b0; pdata = '0; mlast = 1'b0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            v[k]   = ($urandom_range(0, 3) != 0);
            rdq[k] = $urandom_range(0, 1);
            aq[k]  = 12'h100 + 12'($urandom_range(0, 7));
            wq[k]  = $urandom;
            mq[k]  = 4'($urandom_range(0, 15));
            rr[k]  = ($urandom_range(0, 3) != 0);
            set_cmd(k[0], v[k], rdq[k], aq[k], wq[k], mq[k]);
         end
         bus.ch0_rsp_ready = rr[0];
         bus.ch1_rsp_ready = rr[1];
         @(negedge clk);
         can = !pend || rr[pown];
         win = (v[0] && v[1]) ? (RR ? !mlast : 1'b0) : v[1];
         acc = can && (v[0] || v[1]);
         chk("rnd_ready0", bus.ch0_cmd_ready, acc && !win);
         chk("rnd_ready1", bus.ch1_cmd_ready, acc && win);
         chk("rnd_cs", bus.ram_cs, acc);
         chk("rnd_rvalid0", bus.ch0_rsp_valid, pend && !pown);
         chk("rnd_rvalid1", bus.ch1_rsp_valid, pend && pown);
         chk("rnd_rdata0", bus.ch0_rsp_rdata, (pend && !pown) ? pdata : 32'h0);
         chk("rnd_rdata1", bus.ch1_rsp_rdata, (pend && pown) ? pdata : 32'h0);
         if (acc) begin
            chk("rnd_addr", bus.ram_addr, aq[win]);
            chk("rnd_we", bus.ram_we, !rdq[win]);
         end
         if (pend && rr[pown]) pend = 1'b0;
         if (acc) begin
            pdata = rdq[win] ? shadow[aq[win]] : 32'h0;
            if (!rdq[win]) shadow_wr(aq[win], wq[win], mq[win]);
            pend  = 1'b1;
            pown  = win;
            mlast = win;
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
